// File: rtl/block_proc_engine.sv
// Host-mapped word buffer with an in-place byte transform engine.
// Software fills the buffer, starts a run, and the engine rewrites every word once.

module bpe_lane (
  input  logic [1:0] mode,
  input  logic [7:0] offset,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [8:0] sum;

  always_comb begin
    sum = {1'b0, din} + {1'b0, offset};
    case (mode)
      2'd0:    dout = din;
      2'd1:    dout = din ^ 8'h80;
      2'd2:    dout = ~din;
      default: dout = sum[8] ? 8'hFF : sum[7:0];
    endcase
  end
endmodule

module block_proc_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]   host_addr,
  input  logic [DATA_WIDTH-1:0]   host_wdata,
  input  logic [DATA_WIDTH/8-1:0] host_wstrb,
  input  logic                    host_we,
  input  logic                    host_re,
  output logic [DATA_WIDTH-1:0]   host_rdata,
  output logic                    host_rvalid,
  output logic                    irq
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int BSH       = $clog2(NUM_LANES);
  localparam int IW        = $clog2(DEPTH);
  localparam int XW        = ADDR_WIDTH - 1 - BSH;
  localparam int CW        = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [1:0]            mode_q, mode_d;
  logic [7:0]            offset_q, offset_d;
  logic                  irq_en_q, irq_en_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         count_q, count_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] buf_q [DEPTH];
  logic [DATA_WIDTH-1:0] buf_d [DEPTH];

  logic          buf_sel, idx_ok, is_ctrl, is_stat, is_cnt, start, running;
  logic [XW-1:0] widx;
  logic [IW-1:0] widx_lo;

  assign buf_sel = host_addr[ADDR_WIDTH-1];
  assign widx    = host_addr[ADDR_WIDTH-2:BSH];
  assign widx_lo = widx[IW-1:0];
  assign idx_ok  = ({1'b0, widx} < (XW+1)'(DEPTH));
  assign is_ctrl = (host_addr == ADDR_WIDTH'(0));
  assign is_stat = (host_addr == ADDR_WIDTH'(4));
  assign is_cnt  = (host_addr == ADDR_WIDTH'(8));
  assign start   = host_we && is_ctrl && host_wdata[0];
  assign running = (state_q == RUN);

  // Transform datapath: one lane per byte of the word being processed.
  logic [NUM_LANES-1:0][7:0] eng_in, eng_out;
  assign eng_in = buf_q[idx_q];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    bpe_lane u_lane (
      .mode   (mode_q),
      .offset (offset_q),
      .din    (eng_in[l]),
      .dout   (eng_out[l])
    );
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    offset_d = offset_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;
    count_d  = count_q;
    idx_d    = idx_q;

    // mode/offset are frozen while a run is in flight so every word sees the same transform
    if (host_we && is_ctrl) begin
      irq_en_d = host_wdata[3];
      if (!running) begin
        mode_d   = host_wdata[2:1];
        offset_d = host_wdata[15:8];
      end
    end
    if (host_we && is_stat && host_wdata[2]) err_d = 1'b0;

    case (state_q)
      RUN: begin
        idx_d   = idx_q + 1'b1;
        count_d = count_q + 1'b1;
        if (idx_q == IW'(DEPTH - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
        if (start || (host_we && buf_sel)) err_d = 1'b1;
      end
      default: begin
        if (start) begin
          state_d = RUN;
          done_d  = 1'b0;
          count_d = '0;
          idx_d   = '0;
        end else if (state_q == DONE && host_we && is_stat && host_wdata[1]) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    buf_d = buf_q;
    if (running) begin
      buf_d[idx_q] = eng_out;
    end else if (host_we && buf_sel && idx_ok) begin
      for (int b = 0; b < NUM_LANES; b++)
        if (host_wstrb[b]) buf_d[widx_lo][b*8 +: 8] = host_wdata[b*8 +: 8];
    end
  end

  // Reads sample pre-edge state, so a same-cycle write is never visible here.
  always_comb begin
    rdata_d  = '0;
    rvalid_d = host_re;
    if (host_re) begin
      if (buf_sel) begin
        if (idx_ok) rdata_d = buf_q[widx_lo];
      end else if (is_ctrl) begin
        rdata_d[2:1]  = mode_q;
        rdata_d[3]    = irq_en_q;
        rdata_d[15:8] = offset_q;
      end else if (is_stat) begin
        rdata_d[2:0] = {err_q, done_q, running};
      end else if (is_cnt) begin
        rdata_d[CW-1:0] = count_q;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      offset_q <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
      idx_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      offset_q <= offset_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge S_AXI_ACLK) begin
    buf_q <= buf_d;
  end

  assign host_rdata  = rdata_q;
  assign host_rvalid = rvalid_q;
  assign irq         = done_q & irq_en_q;
endmodule

// File: tb/tb_block_proc_engine.sv
// Directed bench for block_proc_engine; read expectations are queued at issue
// and checked when host_rvalid returns.

module tb_block_proc_engine;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int AW = 8;
  localparam logic [AW-1:0] A_CTRL = 8'h00;
  localparam logic [AW-1:0] A_STAT = 8'h04;
  localparam logic [AW-1:0] A_CNT  = 8'h08;
  localparam logic [AW-1:0] A_BUF  = 8'h80;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          irq;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          n_assert = 0;
  int          n_fail = 0;

  block_proc_engine #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .host_addr     (addr),
    .host_wdata    (wdata),
    .host_wstrb    (wstrb),
    .host_we       (we),
    .host_re       (re),
    .host_rdata    (rdata),
    .host_rvalid   (rvalid),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid) begin
      if (exp_q.size() == 0) chk("unexpected_rvalid", {31'b0, rvalid}, 32'd0);
      else chk(tag_q.pop_front(), rdata, exp_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    addr = a; wdata = d; wstrb = s; we = 1'b1;
    step(1);
    we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [31:0] e, input string t);
    addr = a; re = 1'b1;
    exp_q.push_back(e); tag_q.push_back(t);
    step(1);
    re = 1'b0;
  endtask

  task automatic rw(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] e, input string t);
    addr = a; wdata = d; wstrb = 4'hF; we = 1'b1; re = 1'b1;
    exp_q.push_back(e); tag_q.push_back(t);
    step(1);
    we = 1'b0; re = 1'b0;
  endtask

  function automatic logic [AW-1:0] ba(input int i);
    return A_BUF + AW'(i * 4);
  endfunction

  initial begin
    // reset state
    step(2);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    rd(A_CTRL, 32'h0, "rst_ctrl");
    rd(A_STAT, 32'h0, "rst_status");
    rd(A_CNT, 32'h0, "rst_count");

    // mode 1 over a full buffer, busy for exactly DEPTH cycles
    for (int i = 0; i < DEPTH; i++) wr(ba(i), 32'h01010101);
    wr(A_CTRL, 32'h3);
    for (int i = 0; i < DEPTH; i++) rd(A_STAT, 32'h1, "busy_run");
    rd(A_STAT, 32'h2, "done_after_run");
    rd(A_CNT, 32'd16, "count_full");
    for (int i = 0; i < DEPTH; i++) rd(ba(i), 32'h81818181, "mode1_word");
    chk("irq_masked", {31'b0, irq}, 32'h0);
    wr(A_STAT, 32'h2);

    // mode 3 saturating add, then mode 2 invert
    wr(ba(0), 32'h0F10FF00);
    wr(A_CTRL, 32'h0000F007);
    step(17);
    rd(A_STAT, 32'h2, "mode3_done");
    rd(ba(0), 32'hFFFFFFF0, "mode3_word0");
    rd(ba(1), 32'hFFFFFFFF, "mode3_sat");
    rd(A_CTRL, 32'h0000F006, "ctrl_readback");
    wr(A_STAT, 32'h2);
    wr(ba(3), 32'h12345678);
    wr(A_CTRL, 32'h5);
    step(17);
    rd(ba(3), 32'hEDCBA987, "mode2_word3");
    rd(ba(0), 32'h0000000F, "mode2_word0");
    wr(A_STAT, 32'h2);

    // interrupt follows done and clears with W1C
    wr(A_CTRL, 32'h0B);
    chk("irq_start", {31'b0, irq}, 32'h0);
    step(15);
    chk("irq_before_done", {31'b0, irq}, 32'h0);
    step(1);
    chk("irq_at_done", {31'b0, irq}, 32'h1);
    wr(A_STAT, 32'h2);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    rd(A_STAT, 32'h0, "idle_after_w1c");

    // start and buffer write during RUN
    wr(ba(5), 32'hA5A5A5A5);
    wr(A_CTRL, 32'h1);
    wr(A_CTRL, 32'h1);
    wr(ba(5), 32'hDEADBEEF);
    rd(ba(15), 32'h80808080, "read_in_run");
    step(15);
    rd(A_STAT, 32'h6, "err_done");
    rd(A_CNT, 32'd16, "count_after_err");
    rd(ba(5), 32'hA5A5A5A5, "dropped_write");
    wr(A_STAT, 32'h4);
    rd(A_STAT, 32'h2, "err_cleared");
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0, "idle_again");

    // register fields, strobes, simultaneous access, out-of-range index, unmapped
    wr(A_CTRL, 32'hFFFFFF0E);
    rd(A_CTRL, 32'h0000FF0E, "ctrl_fields");
    wr(A_CTRL, 32'h0);
    rd(A_CTRL, 32'h0, "ctrl_zero");
    wr(ba(7), 32'h11111111);
    rw(ba(7), 32'h22222222, 32'h11111111, "rw_old");
    rd(ba(7), 32'h22222222, "rw_new");
    wr(ba(7), 32'hAABBCCDD, 4'h5);
    rd(ba(7), 32'h22BB22DD, "wstrb_partial");
    wr(ba(0), 32'h0);
    wr(ba(16), 32'hFFFFFFFF);
    rd(ba(16), 32'h0, "idx16_read");
    rd(ba(0), 32'h0, "idx16_no_alias");
    rd(8'h0C, 32'h0, "unmapped_read");
    wr(8'h10, 32'hFFFFFFFF);
    rd(A_CTRL, 32'h0, "unmapped_wr_ctrl");
    rd(A_STAT, 32'h0, "unmapped_wr_stat");

    // asynchronous reset mid-run at COUNT=5 with a read response in flight
    wr(A_CTRL, 32'h0B);
    step(4);
    addr = A_STAT; re = 1'b1;
    step(1);
    re = 1'b0;
    chk("mid_rvalid", {31'b0, rvalid}, 32'h1);
    chk("mid_busy", rdata, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rdata", rdata, 32'h0);
    chk("async_rvalid", {31'b0, rvalid}, 32'h0);
    chk("async_irq", {31'b0, irq}, 32'h0);
    step(2);
    rst_n = 1'b1;
    rd(A_STAT, 32'h0, "post_rst_status");
    rd(A_CNT, 32'h0, "post_rst_count");
    rd(A_CTRL, 32'h0, "post_rst_ctrl");

    // reset drops a raised irq without waiting for an edge
    wr(A_CTRL, 32'h0B);
    step(17);
    chk("irq_high_pre_rst", {31'b0, irq}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("irq_async_rst", {31'b0, irq}, 32'h0);
    step(1);
    rst_n = 1'b1;
    rd(A_STAT, 32'h0, "final_status");

    step(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/block_proc_engine.md
BLOCK_PROC_ENGINE -- requirements
Module: block_proc_engine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, host/buffer word width in bits, a multiple of 8, at least 32.
REQ-002 The block SHALL have parameter DEPTH, default 16, buffer depth in words, a power of 2, at least 2.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 8, host byte-address width, with 2^(ADDR_WIDTH-1) >= DEPTH*DATA_WIDTH/8.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-005 The block SHALL have port S_AXI_ACLK  input  1  clock; all logic on the rising edge.
REQ-006 The block SHALL have port S_AXI_ARESETN  input  1  asynchronous active-low reset.
REQ-007 The block SHALL have port host_addr  input  ADDR_WIDTH  byte address, word-aligned.
REQ-008 The block SHALL have port host_wdata  input  DATA_WIDTH  write data.
REQ-009 The block SHALL have port host_wstrb  input  DATA_WIDTH/8  byte enables, used for buffer writes only.
REQ-010 The block SHALL have port host_we  input  1  single-cycle write request.
REQ-011 The block SHALL have port host_re  input  1  single-cycle read request.
REQ-012 The block SHALL have port host_rdata  output  DATA_WIDTH  read data, valid while host_rvalid is high.
REQ-013 The block SHALL have port host_rvalid  output  1  read response strobe.
REQ-014 The block SHALL have port irq  output  1  level interrupt, equal to done AND irq_en.

Function
REQ-015 The address map SHALL be: 0x00 CTRL, 0x04 STATUS, 0x08 COUNT, with addr[ADDR_WIDTH-1]=1 selecting the buffer at word index addr[ADDR_WIDTH-2:log2(DATA_WIDTH/8)]; unmapped reads SHALL return 0 and unmapped writes SHALL be ignored.
REQ-016 CTRL SHALL contain: bit0 start (write-1 pulse, reads 0), bits[2:1] mode, bit3 irq_en, bits[15:8] offset; upper bits read 0, and register writes ignore host_wstrb.
REQ-017 STATUS SHALL contain: bit0 busy (RO), bit1 done (W1C), bit2 err (W1C sticky); COUNT SHALL hold the number of words processed by the current or last run.
REQ-018 A read SHALL return data exactly one cycle after host_re with host_rvalid high for one cycle; when host_we and host_re are both high, the write SHALL be applied and the read SHALL return pre-write contents.
REQ-019 Buffer writes SHALL apply per-byte host_wstrb; buffer indices >= DEPTH SHALL ignore writes and read as 0.
REQ-020 The FSM SHALL have states IDLE, RUN and DONE; a start in IDLE or DONE SHALL load mode/offset, clear done, zero COUNT and enter RUN at the next edge.
REQ-021 In RUN the engine SHALL read-modify-write one buffer word per cycle at index 0..DEPTH-1, increment COUNT per word, and busy SHALL be high for exactly DEPTH cycles.
REQ-022 Per byte b: mode 0 SHALL output b; mode 1 SHALL output b XOR 0x80 (level shift by 128); mode 2 SHALL output NOT b; mode 3 SHALL output min(255, b+offset) as unsigned 9-bit saturating arithmetic.
REQ-023 After the last word, the FSM SHALL enter DONE and set done at that edge; irq SHALL follow combinationally from registered done and irq_en.
REQ-024 A done W1C write in DONE SHALL clear done and irq at the next edge and return the FSM to IDLE.
REQ-025 A start while RUN SHALL be ignored and set err; a host buffer write while RUN SHALL be dropped and set err; buffer reads in RUN SHALL return current contents.
REQ-026 Start and W1C done in the same write SHALL be handled with start taking priority: done cleared and RUN entered.

Reset
REQ-027 Reset assertion SHALL immediately force host_rdata=0, host_rvalid=0, irq=0, FSM=IDLE, and CTRL/STATUS/COUNT=0, including mid-RUN.
REQ-028 Buffer contents SHALL NOT be reset; after a mid-run reset they SHALL be partially processed and left undefined to software.

Verification
REQ-029 The bench SHALL cover: 16 buffer words of 0x01010101, CTRL=0x3 -> busy high 16 cycles, STATUS=0x2, COUNT=16, all words read 0x81818181.
REQ-030 The bench SHALL cover: word 0x0F10FF00, CTRL=0x0000F007 -> result 0xFFFFFFF0; mode 2 on 0x12345678 -> 0xEDCBA987.
REQ-031 The bench SHALL cover: CTRL=0x0B -> irq rises with done; STATUS write 0x2 -> irq=0 and done=0 next cycle, FSM IDLE.
REQ-032 The bench SHALL cover: start and buffer write during RUN -> STATUS bit2=1, the written word is unchanged, COUNT=16; STATUS write 0x4 -> err=0.
REQ-033 The bench SHALL cover: reset asserted at COUNT=5 -> busy, done and irq 0 without a clock edge; after release STATUS=0 and COUNT=0.
REQ-034 The bench SHALL cover: simultaneous we+re on the same buffer word -> old value returned and new value read next; index 16 write -> reads 0.
